cnn_train_sequencer: RTL and testbench

// - Hardware initiator for the CNN core's start/done training handshake.
// - Holds a small on-chip dataset of 4x4 Q8.8 images and labels, and runs a programmed number of epochs.
// - Per sample: presents image/label, pulses start, waits for done, captures the prediction and |pred-label|.
// - Streams per-sample results and per-epoch loss sums to the host.
// - Sits between host config logic and cnn_top_modular; replaces the simulation-only epoch loop.

---
 rtl/cnn_train_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_cnn_train_sequencer.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_train_sequencer.sv
// cnn_train_sequencer: start/done training initiator over a small Q8.8 dataset.
// Optional WAIT watchdog and `timeout` port enabled by CNN_TRAIN_TIMEOUT_EN.
module cnn_train_sequencer #(
    parameter int N_SAMPLES = 2,
    parameter int DW        = 16,
    parameter int EPOCH_W   = 8,
    parameter int LOSS_W    = DW + $clog2(N_SAMPLES) + 1,
    parameter int TIMEOUT   = 1024,
    localparam int SW       = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [SW-1:0]           cfg_sample,
    input  logic [4:0]              cfg_addr,
    input  logic [DW-1:0]           cfg_wdata,
    input  logic                    run,
    input  logic [EPOCH_W-1:0]      num_epochs,
    output logic                    busy,
    output logic                    cnn_start,
    output logic [3:0][3:0][DW-1:0] cnn_image,
    output logic [DW-1:0]           cnn_label,
    input  logic                    cnn_done,
    input  logic [DW-1:0]           cnn_output,
    output logic                    res_valid,
    output logic [EPOCH_W-1:0]      res_epoch,
    output logic [SW-1:0]           res_sample,
    output logic [DW-1:0]           res_pred,
    output logic [DW-1:0]           res_abs_err,
    output logic                    epoch_valid,
    output logic [LOSS_W-1:0]       epoch_loss,
`ifdef CNN_TRAIN_TIMEOUT_EN
    output logic                    timeout,
`endif
    output logic                    all_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START0, S_START1, S_WAIT, S_REPORT
    } state_t;

    localparam logic [DW-1:0] ABS_MAX = {1'b0, {(DW-1){1'b1}}};

    state_t r_state, w_next;

    // word 16 of each sample row holds the label
    logic [16:0][DW-1:0]     r_mem [N_SAMPLES];
    logic [3:0][3:0][DW-1:0] r_image;
    logic [DW-1:0]           r_label;
    logic [DW-1:0]           r_pred;
    logic [SW-1:0]           r_sample;
    logic [EPOCH_W-1:0]      r_epoch;
    logic [EPOCH_W-1:0]      r_num;
    logic [LOSS_W-1:0]       r_loss;
    logic                    r_zero_done;

    logic                    w_idle_run;
    logic                    w_run_go;
    logic                    w_last_s;
    logic                    w_last_e;
    logic [DW:0]             w_err;
    logic [DW:0]             w_mag;
    logic [DW-1:0]           w_abs;
    logic [LOSS_W:0]         w_sum;
    logic [LOSS_W-1:0]       w_loss_next;
    logic                    w_to_fire;
    logic                    w_to_done;

    assign w_idle_run = run && (r_state == S_IDLE);
    assign w_run_go   = w_idle_run && (num_epochs != '0);
    assign w_last_s   = r_sample == SW'(N_SAMPLES - 1);
    assign w_last_e   = r_epoch == (r_num - EPOCH_W'(1));

    assign w_err = {r_pred[DW-1], r_pred} - {r_label[DW-1], r_label};
    assign w_mag = w_err[DW] ? -w_err : w_err;
    assign w_abs = (w_mag > {1'b0, ABS_MAX}) ? ABS_MAX : w_mag[DW-1:0];

    assign w_sum = {1'b0, r_loss} + {{(LOSS_W+1-DW){1'b0}}, w_abs};
    assign w_loss_next = w_sum[LOSS_W] ? '1 : w_sum[LOSS_W-1:0];

`ifdef CNN_TRAIN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] r_wait_cnt;
    logic          r_timeout;
    logic          r_to_done;

    assign w_to_fire = (r_state == S_WAIT) && !cnn_done
                    && (r_wait_cnt == TW'(TIMEOUT - 1));
    assign w_to_done = r_to_done;
    assign timeout   = r_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
            r_to_done  <= 1'b0;
        end else begin
            r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + TW'(1) : '0;
            r_to_done  <= w_to_fire;
            if (w_idle_run)
                r_timeout <= 1'b0;
            else if (w_to_fire)
                r_timeout <= 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_to_fire = 1'b0;
    assign w_to_done = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_run_go) w_next = S_LOAD;
            S_LOAD:   w_next = S_START0;
            S_START0: w_next = S_START1;
            S_START1: w_next = S_WAIT;
            S_WAIT: begin
                if (cnn_done)
                    w_next = S_REPORT;
                else if (w_to_fire)
                    w_next = S_IDLE;
            end
            S_REPORT: w_next = (w_last_s && w_last_e) ? S_IDLE : S_LOAD;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = r_state != S_IDLE;
        cnn_start   = (r_state == S_START0) || (r_state == S_START1);
        res_valid   = r_state == S_REPORT;
        epoch_valid = res_valid && w_last_s;
        epoch_loss  = epoch_valid ? w_loss_next : '0;
        all_done    = (epoch_valid && w_last_e) || r_zero_done || w_to_done;
        res_epoch   = r_epoch;
        res_sample  = r_sample;
        res_pred    = r_pred;
        res_abs_err = w_abs;
        cnn_image   = r_image;
        cnn_label   = r_label;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < N_SAMPLES; s++)
                r_mem[s] <= '0;
            r_image     <= '0;
            r_label     <= '0;
            r_pred      <= '0;
            r_sample    <= '0;
            r_epoch     <= '0;
            r_num       <= '0;
            r_loss      <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= w_idle_run && (num_epochs == '0);
            if (cfg_we && (r_state == S_IDLE) && (cfg_addr <= 5'd16)
                && (32'(cfg_sample) < N_SAMPLES))
                r_mem[cfg_sample][cfg_addr] <= cfg_wdata;
            if (w_run_go) begin
                r_num    <= num_epochs;
                r_sample <= '0;
                r_epoch  <= '0;
                r_loss   <= '0;
            end
            case (r_state)
                S_LOAD: begin
                    r_image <= r_mem[r_sample][15:0];
                    r_label <= r_mem[r_sample][16];
                end
                S_WAIT: if (cnn_done) r_pred <= cnn_output;
                S_REPORT: begin
                    if (w_last_s) begin
                        r_sample <= '0;
                        r_epoch  <= r_epoch + EPOCH_W'(1);
                        r_loss   <= '0;
                    end else begin
                        r_sample <= r_sample + SW'(1);
                        r_loss   <= w_loss_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_train_sequencer.sv
// Bench for cnn_train_sequencer: vector table, corner sequences, and randomized
// runs checked against a behavioural training-loop model.
module tb_cnn_train_sequencer;

    localparam int N    = 2;
    localparam int DW   = 16;
    localparam int EW   = 8;
    localparam int LW   = 18;
    localparam int LMAX = (1 << LW) - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    cfg_we;
    logic [0:0]              cfg_sample;
    logic [4:0]              cfg_addr;
    logic [DW-1:0]           cfg_wdata;
    logic                    run;
    logic [EW-1:0]           num_epochs;
    logic                    busy;
    logic                    cnn_start;
    logic [3:0][3:0][DW-1:0] cnn_image;
    logic [DW-1:0]           cnn_label;
    logic                    cnn_done;
    logic [DW-1:0]           cnn_output;
    logic                    res_valid;
    logic [EW-1:0]           res_epoch;
    logic [0:0]              res_sample;
    logic [DW-1:0]           res_pred;
    logic [DW-1:0]           res_abs_err;
    logic                    epoch_valid;
    logic [LW-1:0]           epoch_loss;
    logic                    all_done;
`ifdef CNN_TRAIN_TIMEOUT_EN
    logic                    timeout;
`endif

    always #5 clk = ~clk;

    cnn_train_sequencer #(
        .N_SAMPLES(N),
        .DW(DW),
`ifdef CNN_TRAIN_TIMEOUT_EN
        .TIMEOUT(16),
`endif
        .EPOCH_W(EW)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_sample(cfg_sample),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .run(run), .num_epochs(num_epochs),
        .busy(busy), .cnn_start(cnn_start),
        .cnn_image(cnn_image), .cnn_label(cnn_label),
        .cnn_done(cnn_done), .cnn_output(cnn_output),
        .res_valid(res_valid), .res_epoch(res_epoch),
        .res_sample(res_sample), .res_pred(res_pred),
        .res_abs_err(res_abs_err), .epoch_valid(epoch_valid),
        .epoch_loss(epoch_loss),
`ifdef CNN_TRAIN_TIMEOUT_EN
        .timeout(timeout),
`endif
        .all_done(all_done)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int c0       = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // core model: answers each start with the next queued prediction
    logic [DW-1:0] resp_q[$];
    int  model_delay = 0;
    bit  model_never = 0;
    bit  m_pend = 0;
    int  m_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            m_pend   = 0;
            cnn_done = 0;
        end else if (cnn_start) begin
            m_pend   = 1;
            m_cnt    = 0;
            cnn_done = 0;
        end else if (m_pend && !model_never) begin
            if (m_cnt == model_delay) begin
                cnn_done   = 1;
                cnn_output = (resp_q.size() != 0) ? resp_q.pop_front() : '0;
                m_pend     = 0;
            end else begin
                m_cnt++;
                cnn_done   = 0;
                cnn_output = 16'($urandom);
            end
        end else begin
            cnn_done   = 0;
            cnn_output = 16'($urandom);
        end
    end

    typedef struct {
        int            ep;
        int            s;
        logic [DW-1:0] pred;
        logic [DW-1:0] abs;
        logic [DW-1:0] lbl;
        logic [DW-1:0] p00;
        logic [DW-1:0] p33;
        int            cyc;
    } res_t;

    res_t          got_q[$];
    logic [LW-1:0] loss_q[$];
    int done_n = 0;
    int done_cyc = 0;
    int start_len = 0;
    int start_bad = 0;
    int start_n = 0;
    int first_start_cyc = -1;

    always @(negedge clk) begin
        if (rst) begin
            start_len = 0;
        end else begin
            if (res_valid)
                got_q.push_back('{ep: int'(res_epoch), s: int'(res_sample),
                                  pred: res_pred, abs: res_abs_err,
                                  lbl: cnn_label, p00: cnn_image[0][0],
                                  p33: cnn_image[3][3], cyc: cyc});
            if (epoch_valid) loss_q.push_back(epoch_loss);
            if (all_done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (cnn_start) begin
                if (start_len == 0) begin
                    start_n++;
                    if (first_start_cyc < 0) first_start_cyc = cyc;
                end
                start_len++;
            end else if (start_len != 0) begin
                if (start_len != 2) start_bad++;
                start_len = 0;
            end
        end
    end

    logic [DW-1:0] g_lbl[N];
    logic [DW-1:0] g_pix[N];
    logic [DW-1:0] exp_resp[$];

    task automatic cfg_write(input int s, input int a, input logic [DW-1:0] d);
        cfg_we     = 1;
        cfg_sample = 1'(s);
        cfg_addr   = 5'(a);
        cfg_wdata  = d;
        @(negedge clk);
        cfg_we     = 0;
    endtask

    task automatic load_sample(input int s, input logic [DW-1:0] pix,
                               input logic [DW-1:0] lbl);
        for (int a = 0; a < 16; a++) cfg_write(s, a, pix);
        cfg_write(s, 16, lbl);
        g_pix[s] = pix;
        g_lbl[s] = lbl;
    endtask

    task automatic prep();
        got_q.delete();
        loss_q.delete();
        done_n = 0;
        start_n = 0;
        start_bad = 0;
        first_start_cyc = -1;
        resp_q = exp_resp;
    endtask

    task automatic pulse_run(input int n);
        run        = 1;
        num_epochs = EW'(n);
        c0         = cyc;
        @(negedge clk);
        run        = 0;
        num_epochs = '0;
    endtask

    task automatic wait_done(input int budget, input string name);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (all_done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check(name, 64'(seen), 64'd1);
    endtask

    // reference: per-sample |pred-label| saturated, summed per epoch
    task automatic check_run(input int n, input string tag);
        int k;
        int p;
        int l;
        int d;
        int acc;
        check({tag, " n_res"}, 64'(got_q.size()), 64'(n * N));
        check({tag, " n_loss"}, 64'(loss_q.size()), 64'(n));
        k = 0;
        for (int e = 0; e < n; e++) begin
            acc = 0;
            for (int s = 0; s < N; s++) begin
                p = $signed(exp_resp[k]);
                l = $signed(g_lbl[s]);
                d = p - l;
                if (d < 0) d = -d;
                if (d > 32767) d = 32767;
                acc = (acc + d > LMAX) ? LMAX : acc + d;
                if (k < got_q.size()) begin
                    check({tag, " ep"}, 64'(got_q[k].ep), 64'(e));
                    check({tag, " sample"}, 64'(got_q[k].s), 64'(s));
                    check({tag, " pred"}, 64'(got_q[k].pred), 64'(exp_resp[k]));
                    check({tag, " abs"}, 64'(got_q[k].abs), 64'(d));
                    check({tag, " label"}, 64'(got_q[k].lbl), 64'(g_lbl[s]));
                    check({tag, " pix00"}, 64'(got_q[k].p00), 64'(g_pix[s]));
                    check({tag, " pix33"}, 64'(got_q[k].p33), 64'(g_pix[s]));
                end
                k++;
            end
            if (e < loss_q.size())
                check({tag, " loss"}, 64'(loss_q[e]), 64'(acc));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " busy"}, 64'(busy), 0);
        check({tag, " start"}, 64'(cnn_start), 0);
        check({tag, " res_valid"}, 64'(res_valid), 0);
        check({tag, " epoch_valid"}, 64'(epoch_valid), 0);
        check({tag, " all_done"}, 64'(all_done), 0);
        check({tag, " image"}, 64'(cnn_image != '0), 0);
        check({tag, " label"}, 64'(cnn_label), 0);
        check({tag, " pred"}, 64'(res_pred), 0);
        check({tag, " abs"}, 64'(res_abs_err), 0);
        check({tag, " loss"}, 64'(epoch_loss), 0);
    endtask

    typedef struct {
        logic [DW-1:0] l0, l1, p0, p1, a0, a1;
        logic [LW-1:0] loss;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1; cfg_we = 0; cfg_sample = 0; cfg_addr = 0; cfg_wdata = 0;
        run = 0; num_epochs = 0; cnn_done = 0; cnn_output = 0;

        tbl[0] = '{16'd256, 16'd0, 16'd256, 16'd0, 16'd0, 16'd0, 18'd0};
        tbl[1] = '{16'd256, 16'd0, 16'd200, 16'd30, 16'd56, 16'd30, 18'd86};
        tbl[2] = '{16'h7FFF, 16'd0, 16'h8000, 16'd0, 16'h7FFF, 16'd0, 18'h7FFF};
        tbl[3] = '{16'hFF00, 16'h0010, 16'h0100, 16'h0000, 16'd512, 16'd16, 18'd528};
        tbl[4] = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF, 18'hFFFE};

        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 0;
        @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            load_sample(0, 16'd256, tbl[v].l0);
            load_sample(1, 16'd0, tbl[v].l1);
            exp_resp = '{tbl[v].p0, tbl[v].p1};
            model_delay = 0;
            prep();
            pulse_run(1);
            check("tbl busy_c1", 64'(busy), 1);
            wait_done(200, "tbl done");
            if (v == 0) begin
                check("lat start", 64'(first_start_cyc), 64'(c0 + 2));
                check("lat done", 64'(cyc), 64'(c0 + 10));
            end
            @(negedge clk);
            check("tbl busy_drop", 64'(busy), 0);
            if (v == 0 && got_q.size() != 0)
                check("lat res", 64'(got_q[0].cyc), 64'(c0 + 5));
            if (got_q.size() == 2 && loss_q.size() == 1) begin
                check("tbl abs0", 64'(got_q[0].abs), 64'(tbl[v].a0));
                check("tbl abs1", 64'(got_q[1].abs), 64'(tbl[v].a1));
                check("tbl loss", 64'(loss_q[0]), 64'(tbl[v].loss));
            end else begin
                check("tbl count", 64'(got_q.size()), 2);
            end
            check_run(1, "tbl");
        end

        // zero epochs: all_done next cycle, no start
        prep();
        pulse_run(0);
        check("zero all_done", 64'(all_done), 1);
        check("zero busy", 64'(busy), 0);
        @(negedge clk);
        check("zero all_done_drop", 64'(all_done), 0);
        repeat (5) @(negedge clk);
        check("zero starts", 64'(start_n), 0);

        // run and cfg_we while busy are ignored
        load_sample(0, 16'd256, 16'd256);
        load_sample(1, 16'd0, 16'd0);
        exp_resp = '{16'd256, 16'd0};
        model_delay = 20;
        prep();
        pulse_run(1);
        repeat (3) @(negedge clk);
        run = 1; num_epochs = 8'd5;
        cfg_we = 1; cfg_sample = 0; cfg_addr = 5'd16; cfg_wdata = 16'd1000;
        @(negedge clk);
        run = 0; num_epochs = 0; cfg_we = 0;
        wait_done(500, "busy done");
        repeat (10) @(negedge clk);
        check_run(1, "busy");
        check("busy starts", 64'(start_n), 2);
        check("busy done_n", 64'(done_n), 1);

        // long run with slow core
        for (int i = 0; i < 40; i++) exp_resp.push_back(16'($urandom));
        exp_resp = exp_resp[2:$];
        load_sample(0, 16'h0123, 16'h0F00);
        load_sample(1, 16'hFE00, 16'hF100);
        model_delay = 7;
        prep();
        pulse_run(20);
        wait_done(3000, "ep20 done");
        repeat (3) @(negedge clk);
        check_run(20, "ep20");
        check("ep20 starts", 64'(start_n), 40);
        check("ep20 start_len", 64'(start_bad), 0);
        check("ep20 done_n", 64'(done_n), 1);

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 4));
            load_sample(0, 16'($urandom), 16'($urandom));
            load_sample(1, 16'($urandom), 16'($urandom));
            exp_resp.delete();
            for (int i = 0; i < n * N; i++) exp_resp.push_back(16'($urandom));
            model_delay = int'($urandom_range(0, 5));
            prep();
            pulse_run(n);
            wait_done(1000, "rnd done");
            repeat (3) @(negedge clk);
            check_run(n, "rnd");
            check("rnd start_len", 64'(start_bad), 0);
            check("rnd done_n", 64'(done_n), 1);
        end

        // reset during WAIT clears state and memory
        model_never = 1;
        exp_resp.delete();
        prep();
        pulse_run(2);
        repeat (6) @(negedge clk);
        check("rst in_wait busy", 64'(busy), 1);
        rst = 1;
        #1;
        check_zero("rst async");
        @(negedge clk);
        check_zero("rst held");
        prep();
        rst = 0;
        model_never = 0;
        repeat (4) @(negedge clk);
        check("rst no_res", 64'(got_q.size()), 0);
        check("rst no_done", 64'(done_n), 0);
        g_lbl[0] = '0; g_lbl[1] = '0; g_pix[0] = '0; g_pix[1] = '0;
        exp_resp = '{16'd5, 16'hFFF0};
        model_delay = 1;
        prep();
        pulse_run(1);
        wait_done(200, "rst done");
        repeat (2) @(negedge clk);
        check_run(1, "rst mem");

`ifdef CNN_TRAIN_TIMEOUT_EN
        model_never = 1;
        exp_resp.delete();
        prep();
        pulse_run(3);
        wait_done(200, "to done");
        check("to cycle", 64'(cyc), 64'(c0 + 20));
        check("to flag", 64'(timeout), 1);
        @(negedge clk);
        check("to busy", 64'(busy), 0);
        check("to no_res", 64'(got_q.size()), 0);
        check("to no_loss", 64'(loss_q.size()), 0);
        model_never = 0;
        exp_resp = '{16'd0, 16'd0};
        prep();
        pulse_run(1);
        check("to clear", 64'(timeout), 0);
        wait_done(200, "to rerun");
        @(negedge clk);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
